// File: rtl/data_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 1024x32 data RAM.
// One access per cycle; read data returns one cycle after the grant.
module data_memory_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic req0, req1;
    logic grant0, grant1;
    logic read_granted;

    logic rd_pending_q, rd_pending_d;
    logic rd_owner_q,   rd_owner_d;
    logic last_grant_q, last_grant_d;

    // Contention goes to whichever master was not granted most recently;
    // a lone requester is granted every cycle.
    always_comb begin
        req0   = m0_read | m0_write;
        req1   = m1_read | m1_write;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!freeze && !reset) begin
            if (req0 && (!req1 || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_write      = 1'b0;
        if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else if (grant0) begin
            mem_write      = m0_write;
        end
    end

    assign mem_chipselect = grant0 | grant1;
    assign mem_clken      = 1'b1;

    // A request with both read and write set is a write, so it never
    // launches a read response.
    assign read_granted = (grant0 & ~m0_write) | (grant1 & ~m1_write);

    always_comb begin
        rd_pending_d = read_granted;
        rd_owner_d   = read_granted ? grant1 : rd_owner_q;
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m0_waitrequest   = req0 & ~grant0;
    assign m1_waitrequest   = req1 & ~grant1;
    assign m0_readdatavalid = rd_pending_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_pending_q &  rd_owner_q;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
